// File: rtl/ahb_burst_master_pkg.sv
// Shared AHB-Lite definitions: bus encodings, master FSM states and beat-count helper.
package Definitions;

    localparam int unsigned ADDRWIDTH = 32;
    localparam int unsigned DATAWIDTH = 32;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } BType_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } Size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_BURST,
        ST_LAST,
        ST_ERR
    } MState_t;

    // Number of beats in a burst; len only matters for undefined-length INCR.
    function automatic logic [4:0] burst_beats(input BType_t burst, input logic [4:0] len);
        logic [4:0] beats;
        case (burst)
            INCR:           beats = (len == 5'd0) ? 5'd1 : len;
            WRAP4, INCR4:   beats = 5'd4;
            WRAP8, INCR8:   beats = 5'd8;
            WRAP16, INCR16: beats = 5'd16;
            default:        beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_burst_master_addr_gen.sv
// Combinational AHB burst address stepper: next beat address, wrap window mask
// and 1 KB boundary-crossing flag for incrementing bursts.
module ahb_addr_gen
    import Definitions::*;
#(
    parameter int unsigned ADDRWIDTH = 32
) (
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [2:0]           burst,
    input  logic [2:0]           size,
    input  logic [4:0]           beats,
    output logic [ADDRWIDTH-1:0] next_addr,
    output logic [ADDRWIDTH-1:0] wrap_mask,
    output logic                 cross_1k
);

    logic [ADDRWIDTH-1:0] incr;
    logic [ADDRWIDTH-1:0] span;
    logic [ADDRWIDTH-1:0] incr_addr;
    logic                 is_wrap;

    // Step the address by one beat, folding it back into the wrap window for WRAPx
    always_comb begin
        incr      = ADDRWIDTH'(1) << size;
        span      = ADDRWIDTH'(beats) << size;
        is_wrap   = BType_t'(burst) inside {WRAP4, WRAP8, WRAP16};
        wrap_mask = is_wrap ? (span - ADDRWIDTH'(1)) : '0;
        incr_addr = addr + incr;
        next_addr = is_wrap ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
        cross_1k  = !is_wrap && (incr_addr[ADDRWIDTH-1:10] != addr[ADDRWIDTH-1:10]);
    end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a NONSEQ/SEQ address sequence
// with pipelined data phases, wait-state and two-cycle ERROR handling.
module ahb_burst_master
    import Definitions::*;
#(
    parameter int unsigned ADDRWIDTH = Definitions::ADDRWIDTH,
    parameter int unsigned DATAWIDTH = Definitions::DATAWIDTH
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [2:0]           cmd_burst,
    input  logic [2:0]           cmd_size,
    input  logic [4:0]           cmd_len,
    input  logic                 cmd_write,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic                 wdata_req,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 done,
    output logic                 err,
    output logic [ADDRWIDTH-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic                 HWRITE,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam logic [2:0]           MAX_SIZE = 3'($clog2(DATAWIDTH / 8));
    localparam logic [ADDRWIDTH-1:0] ONES     = '1;

    MState_t              state, state_next;
    Trans_t               htrans;
    logic [ADDRWIDTH-1:0] haddr_q;
    BType_t               hburst_q;
    logic [2:0]           hsize_q;
    logic                 hwrite_q;
    logic [4:0]           beats_q;
    logic [4:0]           cnt_q;
    logic                 cross_q;
    logic [DATAWIDTH-1:0] hwdata_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 rdata_valid_q;
    logic                 done_q;
    logic                 err_q;

    logic [2:0]           size_c;
    logic [ADDRWIDTH-1:0] addr_c;
    logic [ADDRWIDTH-1:0] next_addr;
    logic [ADDRWIDTH-1:0] wrap_mask;
    logic                 cross_1k;
    logic                 accept_cmd;
    logic                 in_dphase;
    logic                 addr_accept;
    logic                 last_beat;
    logic                 err_first;
    logic                 rd_fire;

    assign size_c = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
    assign addr_c = cmd_addr & (ONES << size_c);

    assign accept_cmd  = (state == ST_IDLE) && cmd_valid;
    // A beat's data phase is outstanding whenever the FSM sits in BURST or LAST
    assign in_dphase   = (state == ST_BURST) || (state == ST_LAST);
    assign err_first   = in_dphase && (Response_t'(HRESP) == ERROR) && !HREADY;
    assign addr_accept = ((state == ST_FIRST) || (state == ST_BURST)) && HREADY;
    assign last_beat   = (cnt_q == (beats_q - 5'd1));
    assign rd_fire     = in_dphase && !hwrite_q && HREADY && (Response_t'(HRESP) == OKAY);

    ahb_addr_gen #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_addr_gen (
        .addr      (haddr_q),
        .burst     (hburst_q),
        .size      (hsize_q),
        .beats     (beats_q),
        .next_addr (next_addr),
        .wrap_mask (wrap_mask),
        .cross_1k  (cross_1k)
    );

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state and HTRANS; the first ERROR cycle cancels the pending address phase
    always_comb begin
        state_next = state;
        htrans     = TR_IDLE;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_next = ST_FIRST;
            end
            ST_FIRST: begin
                htrans = TR_NONSEQ;
                if (HREADY) state_next = last_beat ? ST_LAST : ST_BURST;
            end
            ST_BURST: begin
                if (err_first) begin
                    state_next = ST_ERR;
                end else begin
                    htrans = cross_q ? TR_NONSEQ : TR_SEQ;
                    if (HREADY) state_next = last_beat ? ST_LAST : ST_BURST;
                end
            end
            ST_LAST: begin
                if (err_first)   state_next = ST_ERR;
                else if (HREADY) state_next = ST_IDLE;
            end
            ST_ERR: begin
                if (HREADY) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, address stepping, write data and registered response pulses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q       <= '0;
            hburst_q      <= SINGLE;
            hsize_q       <= '0;
            hwrite_q      <= 1'b0;
            beats_q       <= '0;
            cnt_q         <= '0;
            cross_q       <= 1'b0;
            hwdata_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= rd_fire;
            done_q        <= (state == ST_LAST) && HREADY;
            err_q         <= (state == ST_ERR) && HREADY;
            if (rd_fire) rdata_q <= HRDATA;
            if (accept_cmd) begin
                haddr_q  <= addr_c;
                hburst_q <= BType_t'(cmd_burst);
                hsize_q  <= size_c;
                hwrite_q <= cmd_write;
                beats_q  <= burst_beats(BType_t'(cmd_burst), cmd_len);
                cnt_q    <= '0;
                cross_q  <= 1'b0;
            end else if (addr_accept) begin
                cnt_q <= cnt_q + 5'd1;
                if (hwrite_q) hwdata_q <= wdata;
                if (!last_beat) begin
                    haddr_q <= next_addr;
                    cross_q <= cross_1k;
                end
            end
        end
    end

    // A wrap burst never leaves its aligned window
    assert property (@(posedge HCLK) disable iff (!HRESETn)
        (addr_accept && (wrap_mask != '0)) |-> ((next_addr & ~wrap_mask) == (haddr_q & ~wrap_mask)));

    assign cmd_ready   = (state == ST_IDLE);
    assign wdata_req   = addr_accept && hwrite_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans;
    assign HBURST      = hburst_q;
    assign HSIZE       = hsize_q;
    assign HWRITE      = hwrite_q;
    assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: per-cycle vector table plus error and reset sequences.
module tb_ahb_burst_master;

    localparam logic [1:0] T_IDL = 2'b00;
    localparam logic [1:0] T_NSQ = 2'b10;
    localparam logic [1:0] T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst, cmd_size;
    logic [4:0]  cmd_len;
    logic [31:0] wdata, rdata, HADDR, HWDATA, HRDATA;
    logic        wdata_req, rdata_valid, done, err;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HREADY, HRESP;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_burst_master #(
        .ADDRWIDTH (32),
        .DATAWIDTH (32)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_burst   (cmd_burst),
        .cmd_size    (cmd_size),
        .cmd_len     (cmd_len),
        .cmd_write   (cmd_write),
        .wdata       (wdata),
        .wdata_req   (wdata_req),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .err         (err),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HBURST      (HBURST),
        .HSIZE       (HSIZE),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    typedef struct {
        logic        cv;
        logic [31:0] caddr;
        logic [2:0]  cb;
        logic [2:0]  cs;
        logic [4:0]  cl;
        logic        cw;
        logic        rdy;
        logic [31:0] rdat;
        logic [31:0] wd;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_cready;
        logic        e_wreq;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_done;
        logic        chk_wd;
        logic [31:0] e_hwdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input int cv, input int caddr, input int cb, input int cs,
                                input int cl, input int cw, input int rdy, input int rdat,
                                input int wd, input int et, input int ea, input int ecr,
                                input int ewr, input int erv, input int erd, input int edn,
                                input int cwd, input int ewd);
        vec_t v;
        v.cv = 1'(cv);       v.caddr = 32'(caddr); v.cb = 3'(cb);      v.cs = 3'(cs);
        v.cl = 5'(cl);       v.cw = 1'(cw);        v.rdy = 1'(rdy);    v.rdat = 32'(rdat);
        v.wd = 32'(wd);      v.e_trans = 2'(et);   v.e_addr = 32'(ea); v.e_cready = 1'(ecr);
        v.e_wreq = 1'(ewr);  v.e_rv = 1'(erv);     v.e_rdata = 32'(erd);
        v.e_done = 1'(edn);  v.chk_wd = 1'(cwd);   v.e_hwdata = 32'(ewd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0; cmd_len = '0; cmd_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rv_cnt, done_cnt, err_cnt;
        idle_cmd();
        wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

        //   cv caddr  cb cs cl cw rdy rdat        wd          trans  addr  cr wr rv rdata       dn cw hwdata
        vecs[0]  = mk(1, 'h10,  0, 2, 1, 1, 1, 0,          0,          T_IDL, 0,    1, 0, 0, 0,          0, 0, 0);
        vecs[1]  = mk(0, 0,     0, 0, 0, 0, 1, 0,          'hA5A5A5A5, T_NSQ, 'h10, 0, 1, 0, 0,          0, 0, 0);
        vecs[2]  = mk(0, 0,     0, 0, 0, 0, 1, 0,          0,          T_IDL, 0,    0, 0, 0, 0,          0, 1, 'hA5A5A5A5);
        vecs[3]  = mk(1, 'h38,  2, 2, 1, 0, 1, 0,          0,          T_IDL, 0,    1, 0, 0, 0,          1, 1, 'hA5A5A5A5);
        vecs[4]  = mk(0, 0,     0, 0, 0, 0, 1, 0,          0,          T_NSQ, 'h38, 0, 0, 0, 0,          0, 0, 0);
        vecs[5]  = mk(0, 0,     0, 0, 0, 0, 1, 'h11111111, 0,          T_SEQ, 'h3C, 0, 0, 0, 0,          0, 0, 0);
        vecs[6]  = mk(0, 0,     0, 0, 0, 0, 1, 'h22222222, 0,          T_SEQ, 'h30, 0, 0, 1, 'h11111111, 0, 0, 0);
        vecs[7]  = mk(0, 0,     0, 0, 0, 0, 1, 'h33333333, 0,          T_SEQ, 'h34, 0, 0, 1, 'h22222222, 0, 0, 0);
        vecs[8]  = mk(0, 0,     0, 0, 0, 0, 1, 'h44444444, 0,          T_IDL, 0,    0, 0, 1, 'h33333333, 0, 0, 0);
        vecs[9]  = mk(1, 'h0,   3, 1, 1, 1, 1, 0,          0,          T_IDL, 0,    1, 0, 1, 'h44444444, 1, 0, 0);
        vecs[10] = mk(0, 0,     0, 0, 0, 0, 1, 0,          'h0000AAA1, T_NSQ, 'h0,  0, 1, 0, 0,          0, 0, 0);
        vecs[11] = mk(0, 0,     0, 0, 0, 0, 1, 0,          'h0000AAA2, T_SEQ, 'h2,  0, 1, 0, 0,          0, 1, 'h0000AAA1);
        vecs[12] = mk(0, 0,     0, 0, 0, 0, 0, 0,          'h0000AAA3, T_SEQ, 'h4,  0, 0, 0, 0,          0, 1, 'h0000AAA2);
        vecs[13] = mk(0, 0,     0, 0, 0, 0, 0, 0,          'h0000AAA3, T_SEQ, 'h4,  0, 0, 0, 0,          0, 1, 'h0000AAA2);
        vecs[14] = mk(0, 0,     0, 0, 0, 0, 1, 0,          'h0000AAA3, T_SEQ, 'h4,  0, 1, 0, 0,          0, 1, 'h0000AAA2);
        vecs[15] = mk(0, 0,     0, 0, 0, 0, 1, 0,          'h0000AAA4, T_SEQ, 'h6,  0, 1, 0, 0,          0, 1, 'h0000AAA3);
        vecs[16] = mk(0, 0,     0, 0, 0, 0, 1, 0,          0,          T_IDL, 0,    0, 0, 0, 0,          0, 1, 'h0000AAA4);
        vecs[17] = mk(1, 'h3F8, 1, 2, 4, 0, 1, 0,          0,          T_IDL, 0,    1, 0, 0, 0,          1, 1, 'h0000AAA4);
        vecs[18] = mk(0, 0,     0, 0, 0, 0, 1, 0,          0,          T_NSQ, 'h3F8,0, 0, 0, 0,          0, 0, 0);
        vecs[19] = mk(0, 0,     0, 0, 0, 0, 1, 'hD0000001, 0,          T_SEQ, 'h3FC,0, 0, 0, 0,          0, 0, 0);
        vecs[20] = mk(0, 0,     0, 0, 0, 0, 1, 'hD0000002, 0,          T_NSQ, 'h400,0, 0, 1, 'hD0000001, 0, 0, 0);
        vecs[21] = mk(0, 0,     0, 0, 0, 0, 1, 'hD0000003, 0,          T_SEQ, 'h404,0, 0, 1, 'hD0000002, 0, 0, 0);
        vecs[22] = mk(0, 0,     0, 0, 0, 0, 1, 'hD0000004, 0,          T_IDL, 0,    0, 0, 1, 'hD0000003, 0, 0, 0);
        vecs[23] = mk(0, 0,     0, 0, 0, 0, 1, 0,          0,          T_IDL, 0,    1, 0, 1, 'hD0000004, 1, 0, 0);

        // Reset values while HRESETn is held low
        #12;
        chk("rst HTRANS", 32'(HTRANS), 32'(T_IDL));
        chk("rst HADDR", HADDR, 32'h0);
        chk("rst HBURST", 32'(HBURST), 32'h0);
        chk("rst HSIZE", 32'(HSIZE), 32'h0);
        chk("rst HWDATA", HWDATA, 32'h0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst pulses", {27'h0, wdata_req, rdata_valid, done, err, HWRITE}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Cycle table: SINGLE write, WRAP4 read, INCR4 write with waits, INCR 1 KB crossing
        for (int i = 0; i < NV; i++) begin
            @(posedge HCLK); #1;
            cmd_valid = vecs[i].cv;  cmd_addr = vecs[i].caddr; cmd_burst = vecs[i].cb;
            cmd_size  = vecs[i].cs;  cmd_len  = vecs[i].cl;    cmd_write = vecs[i].cw;
            HREADY    = vecs[i].rdy; HRDATA   = vecs[i].rdat;  wdata     = vecs[i].wd;
            HRESP     = 1'b0;
            @(negedge HCLK);
            chk($sformatf("v%0d HTRANS", i), 32'(HTRANS), 32'(vecs[i].e_trans));
            if (vecs[i].e_trans != T_IDL) chk($sformatf("v%0d HADDR", i), HADDR, vecs[i].e_addr);
            chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_cready));
            chk($sformatf("v%0d wdata_req", i), 32'(wdata_req), 32'(vecs[i].e_wreq));
            chk($sformatf("v%0d rdata_valid", i), 32'(rdata_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) chk($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d err", i), 32'(err), 32'h0);
            if (vecs[i].chk_wd) chk($sformatf("v%0d HWDATA", i), HWDATA, vecs[i].e_hwdata);
        end

        // ERROR on beat 2 of an INCR8 read; oversize request clamped and aligned
        rv_cnt = 0; done_cnt = 0; err_cnt = 0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h103; cmd_burst = 3'd5; cmd_size = 3'd3; cmd_len = 5'd0; cmd_write = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        chk("e cmd_ready", 32'(cmd_ready), 32'h1);
        @(posedge HCLK); #1; idle_cmd();
        @(negedge HCLK);
        chk("e first HTRANS", 32'(HTRANS), 32'(T_NSQ));
        chk("e first HADDR", HADDR, 32'h100);
        chk("e HBURST", 32'(HBURST), 32'h5);
        chk("e HSIZE clamp", 32'(HSIZE), 32'h2);
        @(posedge HCLK); #1; HRDATA = 32'hBEEF0001;
        @(negedge HCLK);
        chk("e beat2 HTRANS", 32'(HTRANS), 32'(T_SEQ));
        chk("e beat2 HADDR", HADDR, 32'h104);
        rv_cnt += int'(rdata_valid);
        @(posedge HCLK); #1; HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hDEAD0002;
        @(negedge HCLK);
        chk("e cancel HTRANS", 32'(HTRANS), 32'(T_IDL));
        chk("e beat1 rdata", rdata, 32'hBEEF0001);
        rv_cnt += int'(rdata_valid); done_cnt += int'(done); err_cnt += int'(err);
        @(posedge HCLK); #1; HREADY = 1'b1; HRESP = 1'b1;
        @(negedge HCLK);
        chk("e err2 HTRANS", 32'(HTRANS), 32'(T_IDL));
        chk("e err2 cmd_ready", 32'(cmd_ready), 32'h0);
        rv_cnt += int'(rdata_valid); done_cnt += int'(done); err_cnt += int'(err);
        @(posedge HCLK); #1; HRESP = 1'b0;
        @(negedge HCLK);
        chk("e err pulse", 32'(err), 32'h1);
        chk("e back idle", 32'(cmd_ready), 32'h1);
        rv_cnt += int'(rdata_valid); done_cnt += int'(done); err_cnt += int'(err);
        for (int k = 0; k < 3; k++) begin
            @(posedge HCLK); #1;
            @(negedge HCLK);
            rv_cnt += int'(rdata_valid); done_cnt += int'(done); err_cnt += int'(err);
        end
        chk("e rdata_valid count", 32'(rv_cnt), 32'd1);
        chk("e done count", 32'(done_cnt), 32'd0);
        chk("e err count", 32'(err_cnt), 32'd1);

        // Asynchronous reset during beat 3 of an INCR16 write
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_burst = 3'd7; cmd_size = 3'd2; cmd_len = 5'd0; cmd_write = 1'b1;
        wdata = 32'h12345678; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1; idle_cmd();
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("r beat3 HTRANS", 32'(HTRANS), 32'(T_SEQ));
        chk("r beat3 HADDR", HADDR, 32'h208);
        chk("r beat3 wdata_req", 32'(wdata_req), 32'h1);
        chk("r beat3 HWDATA", HWDATA, 32'h12345678);
        #1; HRESETn = 1'b0; #1;
        chk("r HTRANS", 32'(HTRANS), 32'(T_IDL));
        chk("r HADDR", HADDR, 32'h0);
        chk("r HBURST", 32'(HBURST), 32'h0);
        chk("r HSIZE", 32'(HSIZE), 32'h0);
        chk("r HWDATA", HWDATA, 32'h0);
        chk("r cmd_ready", 32'(cmd_ready), 32'h1);
        chk("r pulses", {27'h0, wdata_req, rdata_valid, done, err, HWRITE}, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK); HRESETn = 1'b1;
        done_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge HCLK); #1;
            @(negedge HCLK);
            done_cnt += int'(done); err_cnt += int'(err);
        end
        chk("r release cmd_ready", 32'(cmd_ready), 32'h1);
        chk("r release HTRANS", 32'(HTRANS), 32'(T_IDL));
        chk("r no done/err", 32'(done_cnt + err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
